// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi
// Brief    : NUM_CH independent runtime-programmable clock dividers with a
//            valid/ready divisor port; new divisors take effect on period
//            boundaries. Define CLKDIV_STATUS_EN to expose phase/pending.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_multi #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 28,
    parameter int RESET_DIV = 4,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [DIV_W-1:0]         cfg_div,
    output logic [NUM_CH-1:0]        CLK,
    output logic [NUM_CH-1:0]        tick
`ifdef CLKDIV_STATUS_EN
    ,
    output logic [NUM_CH*DIV_W-1:0]  phase,
    output logic [NUM_CH-1:0]        pending
`endif
);

    localparam logic [DIV_W-1:0] C_RESET_DIV = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] C_ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] C_TWO       = DIV_W'(2);

    logic [DIV_W-1:0]  r_cnt      [NUM_CH];
    logic [DIV_W-1:0]  r_div_act  [NUM_CH];
    logic [DIV_W-1:0]  r_div_pend [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_clk;
    logic [NUM_CH-1:0] r_tick;

    logic [NUM_CH-1:0] w_run;
    logic [NUM_CH-1:0] w_last;
    logic [NUM_CH-1:0] w_apply;
    logic [NUM_CH-1:0] w_acc;

    // Out-of-range channel selects read as ready so such writes drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~r_pend[i];
            end
        end
    end

    always_comb begin
        w_run   = '0;
        w_last  = '0;
        w_apply = '0;
        w_acc   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_run[i]   = en[i] && (r_div_act[i] >= C_TWO);
            w_last[i]  = (r_cnt[i] == (r_div_act[i] - C_ONE));
            w_apply[i] = r_pend[i] && (!w_run[i] || w_last[i]);
            w_acc[i]   = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    // Accept and apply never coincide on a channel: accept needs pend low, apply needs it high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]      <= '0;
                r_div_act[i]  <= C_RESET_DIV;
                r_div_pend[i] <= '0;
            end
            r_pend <= '0;
            r_clk  <= '0;
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_acc[i]) begin
                    r_div_pend[i] <= cfg_div;
                    r_pend[i]     <= 1'b1;
                end
                if (w_apply[i]) begin
                    r_div_act[i] <= r_div_pend[i];
                    r_cnt[i]     <= '0;
                    r_pend[i]    <= 1'b0;
                end else if (w_run[i]) begin
                    r_cnt[i] <= w_last[i] ? '0 : (r_cnt[i] + C_ONE);
                end else begin
                    r_cnt[i] <= '0;
                end
                r_clk[i]  <= w_run[i] && (r_cnt[i] < (r_div_act[i] >> 1));
                r_tick[i] <= w_run[i] && (r_cnt[i] == '0);
            end
        end
    end

    assign CLK  = r_clk;
    assign tick = r_tick;

`ifdef CLKDIV_STATUS_EN
    always_comb begin
        phase = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            phase[i*DIV_W +: DIV_W] = r_cnt[i];
        end
    end
    assign pending = r_pend;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_multi
// Brief    : Randomised and directed bench for clock_divider_multi against a
//            time-based period model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_multi;

    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 28;
    localparam int RESET_DIV = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [0:0]              cfg_ch;
    logic [DIV_W-1:0]        cfg_div;
    logic [NUM_CH-1:0]       CLK;
    logic [NUM_CH-1:0]       tick;
`ifdef CLKDIV_STATUS_EN
    logic [NUM_CH*DIV_W-1:0] phase;
    logic [NUM_CH-1:0]       pending;
`endif

    clock_divider_multi #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .CLK       (CLK),
        .tick      (tick)
`ifdef CLKDIV_STATUS_EN
        ,
        .phase     (phase),
        .pending   (pending)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: each running channel's phase is (cycle - period start) mod divisor.
    int  m_act   [NUM_CH];
    int  m_pd    [NUM_CH];
    int  m_start [NUM_CH];
    bit  m_pend  [NUM_CH];
    int  n = 0;

    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] exp_tick;
    logic              exp_ready;
    logic              act_ready;

    function automatic bit m_run(int c);
        return en[c] && (m_act[c] >= 2);
    endfunction

    function automatic int m_phase(int c);
        if (!m_run(c)) return 0;
        return (n - m_start[c]) % m_act[c];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c]   = RESET_DIV;
            m_pd[c]    = 0;
            m_pend[c]  = 1'b0;
            m_start[c] = n;
        end
    endtask

    // One clock cycle: predict outputs of the coming edge, clock it, update model.
    task automatic advance();
        bit took;
        int tch;
        int tdiv;
        int ph;
        bit rn [NUM_CH];
        bit ap [NUM_CH];
        #1;
        act_ready = cfg_ready;
        exp_ready = !m_pend[cfg_ch];
        took      = cfg_valid && exp_ready;
        tch       = int'(cfg_ch);
        tdiv      = int'(cfg_div);
        for (int c = 0; c < NUM_CH; c++) begin
            rn[c]       = m_run(c);
            ph          = m_phase(c);
            exp_clk[c]  = rn[c] && (ph < m_act[c] / 2);
            exp_tick[c] = rn[c] && (ph == 0);
            ap[c]       = m_pend[c] && (!rn[c] || ph == m_act[c] - 1);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ap[c]) begin
                m_act[c]   = m_pd[c];
                m_pend[c]  = 1'b0;
                m_start[c] = n + 1;
            end else if (!rn[c]) begin
                m_start[c] = n + 1;
            end
        end
        if (took) begin
            m_pend[tch] = 1'b1;
            m_pd[tch]   = tdiv;
        end
        n++;
    endtask

    task automatic test_reset();
        logic [NUM_CH-1:0] e_clk;
        logic [NUM_CH-1:0] e_tick;
        rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        #12;
        total++; if (CLK !== 2'b00) begin bad++; $display("FAIL reset_clk got=%b exp=00", CLK); end
        total++; if (tick !== 2'b00) begin bad++; $display("FAIL reset_tick got=%b exp=00", tick); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        en = 2'b01;
        for (int i = 0; i < 12; i++) begin
            advance();
            e_clk  = {1'b0, ((i % 4) < 2)};
            e_tick = {1'b0, ((i % 4) == 0)};
            total++; if (CLK !== e_clk) begin bad++; $display("FAIL reset_run_clk cyc=%0d got=%b exp=%b", i, CLK, e_clk); end
            total++; if (tick !== e_tick) begin bad++; $display("FAIL reset_run_tick cyc=%0d got=%b exp=%b", i, tick, e_tick); end
        end
    endtask

    task automatic test_reconfig();
        bit found = 1'b0;
        cfg_ch = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_phase(0) == 1) found = 1'b1;
            else advance();
        end
        total++; if (!found) begin bad++; $display("FAIL reconfig_align got=none exp=cnt1"); end
        cfg_valid = 1'b1; cfg_div = 28'd6;
        advance();
        cfg_valid = 1'b0;
        total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL reconfig_accept got=%b exp=1", act_ready); end
        for (int i = 0; i < 16; i++) begin
            advance();
            total++; if (CLK !== exp_clk) begin bad++; $display("FAIL reconfig_clk cyc=%0d got=%b exp=%b", i, CLK, exp_clk); end
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL reconfig_tick cyc=%0d got=%b exp=%b", i, tick, exp_tick); end
            total++; if (act_ready !== exp_ready) begin bad++; $display("FAIL reconfig_ready cyc=%0d got=%b exp=%b", i, act_ready, exp_ready); end
        end
    endtask

    task automatic test_pend_block();
        cfg_ch = 1'b0;
        for (int i = 0; i < 8 && m_phase(0) != 0; i++) advance();
        cfg_valid = 1'b1; cfg_div = 28'd8;
        advance();
        total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL block_first got=%b exp=1", act_ready); end
        cfg_div = 28'd5;
        advance();
        total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL block_second got=%b exp=0", act_ready); end
        cfg_ch = 1'b1; cfg_div = 28'd7;
        advance();
        total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL block_ch1 got=%b exp=1", act_ready); end
        cfg_valid = 1'b0;
        advance();
        total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL block_ch1_pend got=%b exp=0", act_ready); end
        cfg_ch = 1'b0;
        for (int i = 0; i < 20; i++) begin
            advance();
            total++; if (CLK !== exp_clk) begin bad++; $display("FAIL block_clk cyc=%0d got=%b exp=%b", i, CLK, exp_clk); end
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL block_tick cyc=%0d got=%b exp=%b", i, tick, exp_tick); end
            total++; if (act_ready !== exp_ready) begin bad++; $display("FAIL block_ready cyc=%0d got=%b exp=%b", i, act_ready, exp_ready); end
        end
    endtask

    task automatic test_stopped_apply();
        en[1] = 1'b0;
        cfg_ch = 1'b1; cfg_div = 28'd3; cfg_valid = 1'b1;
        advance();
        cfg_valid = 1'b0;
        advance();
        total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL stop_pend got=%b exp=0", act_ready); end
        advance();
        total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL stop_applied got=%b exp=1", act_ready); end
        en[1] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            advance();
            total++; if (CLK[1] !== ((i % 3) == 0)) begin bad++; $display("FAIL stop_clk1 cyc=%0d got=%b exp=%b", i, CLK[1], ((i % 3) == 0)); end
            total++; if (tick[1] !== ((i % 3) == 0)) begin bad++; $display("FAIL stop_tick1 cyc=%0d got=%b exp=%b", i, tick[1], ((i % 3) == 0)); end
            total++; if (CLK !== exp_clk) begin bad++; $display("FAIL stop_clk cyc=%0d got=%b exp=%b", i, CLK, exp_clk); end
        end
    endtask

    task automatic test_div01();
        cfg_ch = 1'b0; cfg_div = 28'd1; cfg_valid = 1'b1;
        advance();
        cfg_valid = 1'b0;
        total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL div1_accept got=%b exp=1", act_ready); end
        for (int i = 0; i < 12; i++) begin
            advance();
            total++; if (CLK !== exp_clk) begin bad++; $display("FAIL div1_clk cyc=%0d got=%b exp=%b", i, CLK, exp_clk); end
        end
        for (int i = 0; i < 6; i++) begin
            advance();
            total++; if (CLK[0] !== 1'b0 || tick[0] !== 1'b0) begin bad++; $display("FAIL div1_stopped cyc=%0d got=%b%b exp=00", i, CLK[0], tick[0]); end
        end
        cfg_div = 28'd2; cfg_valid = 1'b1;
        advance();
        cfg_valid = 1'b0;
        advance();
        for (int i = 0; i < 8; i++) begin
            advance();
            total++; if (CLK[0] !== ((i % 2) == 0)) begin bad++; $display("FAIL div2_clk cyc=%0d got=%b exp=%b", i, CLK[0], ((i % 2) == 0)); end
            total++; if (tick[0] !== ((i % 2) == 0)) begin bad++; $display("FAIL div2_tick cyc=%0d got=%b exp=%b", i, tick[0], ((i % 2) == 0)); end
        end
    endtask

    task automatic test_large();
        en[1] = 1'b0;
        advance();
        advance();
        cfg_ch = 1'b1; cfg_div = 28'hFFF_FFFF; cfg_valid = 1'b1;
        advance();
        cfg_valid = 1'b0;
        advance();
        en[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            advance();
            total++; if (CLK[1] !== 1'b1) begin bad++; $display("FAIL large_clk cyc=%0d got=%b exp=1", i, CLK[1]); end
            total++; if (tick[1] !== (i == 0)) begin bad++; $display("FAIL large_tick cyc=%0d got=%b exp=%b", i, tick[1], (i == 0)); end
        end
        en[1] = 1'b0;
        cfg_ch = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(15) == 0) en[0] = ~en[0];
            if ($urandom_range(15) == 0) en[1] = ~en[1];
            cfg_valid = ($urandom_range(3) == 0);
            cfg_ch    = 1'($urandom_range(1));
            cfg_div   = DIV_W'($urandom_range(9));
            advance();
            total++; if (CLK !== exp_clk) begin bad++; $display("FAIL rand_clk cyc=%0d got=%b exp=%b", i, CLK, exp_clk); end
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", i, tick, exp_tick); end
            total++; if (act_ready !== exp_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, act_ready, exp_ready); end
`ifdef CLKDIV_STATUS_EN
            total++; if (pending !== {m_pend[1], m_pend[0]}) begin bad++; $display("FAIL rand_pending cyc=%0d got=%b exp=%b%b", i, pending, m_pend[1], m_pend[0]); end
`endif
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        en = 2'b00; cfg_valid = 1'b0; cfg_ch = 1'b0;
        advance();
        advance();
        cfg_div = 28'd6; cfg_valid = 1'b1;
        advance();
        cfg_valid = 1'b0;
        advance();
        en = 2'b01;
        advance();
        advance();
        cfg_div = 28'd7; cfg_valid = 1'b1;
        advance();
        cfg_valid = 1'b0;
        total++; if (CLK[0] !== 1'b1) begin bad++; $display("FAIL arst_pre_clk got=%b exp=1", CLK[0]); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (CLK !== 2'b00 || tick !== 2'b00) begin bad++; $display("FAIL arst_outputs got=%b/%b exp=00/00", CLK, tick); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL arst_pend got=%b exp=1", cfg_ready); end
        for (int i = 0; i < 8; i++) begin
            advance();
            total++; if (CLK[0] !== ((i % 4) < 2)) begin bad++; $display("FAIL arst_clk cyc=%0d got=%b exp=%b", i, CLK[0], ((i % 4) < 2)); end
            total++; if (tick[0] !== ((i % 4) == 0)) begin bad++; $display("FAIL arst_tick cyc=%0d got=%b exp=%b", i, tick[0], ((i % 4) == 0)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reconfig();
        test_pend_block();
        test_stopped_apply();
        test_div01();
        test_large();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
